// File: rtl/ps2_receiver.sv
// PS/2 host-side receiver: synchronizes and glitch-filters the device clock,
// deframes 11-bit frames, and decodes E0/F0 scan-code prefixes into key events.
module ps2_receiver #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1, clk_s2;
    logic          data_s1, data_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] timer;
    logic          break_pend, ext_pend;

    // NOTE: every register here uses non-blocking assignment so all flops
    // update together on the clock edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1  <= 1'b0;
            clk_s2  <= 1'b0;
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // The filtered clock only follows a level that has been held for FILTER_LEN samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_break  <= 1'b0;
            key_ext    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            key_valid <= 1'b0;

            if (state == IDLE) begin
                timer <= '0;
                if (fall && !data_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (fall) begin
                timer <= '0;
                case (state)
                    DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (data_s2 && (^{shift, par_bit})) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            if (shift == 8'hF0) begin
                                break_pend <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else begin
                                key_code   <= shift;
                                key_valid  <= 1'b1;
                                key_break  <= break_pend;
                                key_ext    <= ext_pend;
                                break_pend <= 1'b0;
                                ext_pend   <= 1'b0;
                            end
                        end else begin
                            rx_err     <= 1'b1;
                            break_pend <= 1'b0;
                            ext_pend   <= 1'b0;
                        end
                    end
                endcase
            end else if (timer == TW'(TIMEOUT - 1)) begin
                // Device stalled mid-frame: drop the partial byte.
                state      <= IDLE;
                rx_err     <= 1'b1;
                break_pend <= 1'b0;
                ext_pend   <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed frame table, stall/glitch/reset
// sequences, and random frames scored against a frame-level reference model.
module tb_ps2_receiver;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;

    ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_break (key_break),
        .key_ext   (key_ext)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_err = 0, n_key = 0, n_both = 0;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_err) n_err++;
        if (key_valid) n_key++;
        if (rx_valid && rx_err) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ pflip);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (60) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pflip;
        logic       stop;
        logic [7:0] exp_rx;
        int         exp_valid;
        int         exp_err;
        int         exp_key;
        logic [7:0] exp_code;
        logic       exp_brk;
        logic       exp_ext;
    } vec_t;

    vec_t vecs[10];

    // Frame-level reference model state.
    logic [7:0] m_rx, m_code;
    logic       m_brk, m_ext, m_bpend, m_epend;

    int v0, e0, k0;

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        k0 = n_key;
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{8'hE0, 1'b0, 1'b1, 8'hE0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[2] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[3] = '{8'h75, 1'b0, 1'b1, 8'h75, 1, 0, 1, 8'h75, 1'b1, 1'b1};
        vecs[4] = '{8'h75, 1'b0, 1'b1, 8'h75, 1, 0, 1, 8'h75, 1'b0, 1'b0};
        vecs[5] = '{8'h1C, 1'b1, 1'b1, 8'h75, 0, 1, 0, 8'h75, 1'b0, 1'b0};
        vecs[6] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 1, 8'h1C, 1'b0, 1'b0};
        vecs[7] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0, 0, 8'h1C, 1'b0, 1'b0};
        vecs[8] = '{8'h12, 1'b0, 1'b0, 8'hF0, 0, 1, 0, 8'h1C, 1'b0, 1'b0};
        vecs[9] = '{8'h12, 1'b0, 1'b1, 8'h12, 1, 0, 1, 8'h12, 1'b0, 1'b0};

        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_err", rx_err, 0);
        check("reset key_code", key_code, 0);
        check("reset key_valid", key_valid, 0);
        check("reset key_break", key_break, 0);
        check("reset key_ext", key_ext, 0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("vec%0d valid count", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d err count", i), n_err - e0, vecs[i].exp_err);
            check($sformatf("vec%0d key count", i), n_key - k0, vecs[i].exp_key);
            check($sformatf("vec%0d key_code", i), key_code, vecs[i].exp_code);
            check($sformatf("vec%0d key_break", i), key_break, vecs[i].exp_brk);
            check($sformatf("vec%0d key_ext", i), key_ext, vecs[i].exp_ext);
        end

        // Stall after four data bits; receiver must time out exactly once.
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        check("timeout err count", n_err - e0, 1);
        check("timeout valid count", n_valid - v0, 0);
        check("timeout rx_data held", rx_data, 8'h12);
        snap();
        send_frame(8'h29, 1'b0, 1'b1);
        check("post-timeout rx_data", rx_data, 8'h29);
        check("post-timeout key_code", key_code, 8'h29);
        check("post-timeout valid count", n_valid - v0, 1);
        check("post-timeout err count", n_err - e0, 0);

        // Short low glitch on ps2_clk while idle with data low.
        snap();
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FILTER_LEN - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch strobes", (n_valid - v0) + (n_err - e0) + (n_key - k0), 0);
        send_frame(8'h33, 1'b0, 1'b1);
        check("post-glitch rx_data", rx_data, 8'h33);
        check("post-glitch valid count", n_valid - v0, 1);
        check("post-glitch err count", n_err - e0, 0);

        // Reset in the middle of a frame.
        snap();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset rx_data", rx_data, 0);
        check("midreset key_code", key_code, 0);
        check("midreset key_break", key_break, 0);
        check("midreset key_ext", key_ext, 0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("midreset strobes", (n_valid - v0) + (n_err - e0) + (n_key - k0), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("post-reset rx_data", rx_data, 8'h5A);
        check("post-reset key_code", key_code, 8'h5A);
        check("post-reset valid count", n_valid - v0, 1);
        check("post-reset err count", n_err - e0, 0);

        // Random frames against the reference model.
        m_rx = 8'h5A; m_code = 8'h5A; m_brk = 1'b0; m_ext = 1'b0;
        m_bpend = 1'b0; m_epend = 1'b0;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic       pflip, stop, good, is_key;
            if ($urandom_range(0, 4) == 0)      b = 8'hF0;
            else if ($urandom_range(0, 4) == 0) b = 8'hE0;
            else                                b = 8'($urandom);
            pflip  = ($urandom_range(0, 5) == 0);
            stop   = ($urandom_range(0, 7) != 0);
            good   = !pflip && stop;
            is_key = good && b != 8'hF0 && b != 8'hE0;
            if (good) begin
                m_rx = b;
                if (b == 8'hF0) m_bpend = 1'b1;
                else if (b == 8'hE0) m_epend = 1'b1;
                else begin
                    m_code = b; m_brk = m_bpend; m_ext = m_epend;
                    m_bpend = 1'b0; m_epend = 1'b0;
                end
            end else begin
                m_bpend = 1'b0; m_epend = 1'b0;
            end
            snap();
            send_frame(b, pflip, stop);
            check($sformatf("rnd%0d rx_data", n), rx_data, m_rx);
            check($sformatf("rnd%0d valid count", n), n_valid - v0, good ? 1 : 0);
            check($sformatf("rnd%0d err count", n), n_err - e0, good ? 0 : 1);
            check($sformatf("rnd%0d key count", n), n_key - k0, is_key ? 1 : 0);
            check($sformatf("rnd%0d key_code", n), key_code, m_code);
            check($sformatf("rnd%0d key_break", n), key_break, m_brk);
            check($sformatf("rnd%0d key_ext", n), key_ext, m_ext);
        end

        check("valid and err never together", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required before the filtered clock changes level.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles allowed between consecutive filtered falling edges within one frame.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 device clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 device data, asynchronous to clk.
REQ-007 rx_data  output  8  last received byte, held until the next valid byte.
REQ-008 rx_valid  output  1  one-cycle strobe: rx_data updated with a good byte.
REQ-009 rx_err  output  1  one-cycle strobe: parity, stop-bit or timeout error.
REQ-010 key_code  output  8  last non-prefix scan code, held.
REQ-011 key_valid  output  1  one-cycle strobe: key_code, key_break and key_ext updated.
REQ-012 key_break  output  1  the key event was preceded by an 0xF0 prefix.
REQ-013 key_ext  output  1  the key event was preceded by an 0xE0 prefix.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 The filtered clock SHALL take the synchronized ps2_clk level after FILTER_LEN consecutive equal samples; shorter glitches SHALL be ignored.
REQ-016 A falling edge SHALL be a 1->0 change of the filtered clock; synchronized ps2_data SHALL be sampled in the same cycle the edge is detected.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: edge with data=0 -> DATA with bit counter=0; edge with data=1 -> stay in IDLE, no error.
REQ-019 DATA: each edge shifts data in LSB-first; after the 8th bit -> PARITY.
REQ-020 PARITY: the edge captures the parity bit -> STOP.
REQ-021 STOP: the edge returns the FSM to IDLE. If parity is odd over the 8 data bits plus the parity bit and stop=1, the byte is good; otherwise rx_err pulses.
REQ-022 For a good byte, rx_valid SHALL pulse and rx_data update in the cycle after the stop-bit edge; rx_valid and rx_err SHALL never be high together.
REQ-023 A timeout counter SHALL restart on every edge while the FSM is not in IDLE; on reaching TIMEOUT the FSM SHALL go to IDLE, rx_err SHALL pulse once, and partial data SHALL be discarded.
REQ-024 Good byte 0xF0 SHALL set break_pend; good byte 0xE0 SHALL set ext_pend; neither SHALL pulse key_valid.
REQ-025 Any other good byte SHALL, in the same cycle as rx_valid:
- pulse key_valid;
- load key_code;
- copy break_pend to key_break and ext_pend to key_ext;
- clear both pending flags.
REQ-026 rx_err SHALL clear both pending flags and SHALL leave rx_data, key_code, key_break and key_ext unchanged.
REQ-027 A filtered-clock rising edge SHALL have no effect on FSM state.

Reset
REQ-028 While reset=0, the following SHALL be 0:
- all outputs;
- pending flags and counters;
- synchronizer flops.
The filtered clock SHALL be 1 and the FSM SHALL be in IDLE.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_valid or rx_err strobe; the receiver SHALL restart at IDLE on the first edge after release.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1 -> exactly one rx_valid and one key_valid; rx_data=key_code=0x1C; key_break=0, key_ext=0.
REQ-031 Frames 0xE0, 0xF0, 0x75 -> three rx_valid strobes and one key_valid; key_code=0x75, key_break=1, key_ext=1; a following 0x75 gives key_break=0, key_ext=0.
REQ-032 Frame 0x1C with parity 1 -> rx_err pulses once; no rx_valid; rx_data unchanged; a following good 0x1C is received normally.
REQ-033 Frame stopped after 4 data bits, ps2_clk held high for more than TIMEOUT cycles -> one rx_err, FSM in IDLE; the next full frame 0x29 is received correctly.
REQ-034 ps2_clk glitches low for FILTER_LEN-2 cycles while IDLE with data=0 -> no state change and no strobes.
REQ-035 reset=0 asserted after the 5th data bit, then released -> no strobes during or after reset; the next frame 0x5A gives rx_data=0x5A.
